window3x3_gen: RTL and testbench
================================

// Module: window3x3_gen
// PURPOSE
//  Consumes a raster pixel stream and emits a 3x3 pixel neighbourhood per pixel for downstream
//  spatial filters (median, Sobel, Gaussian). Internally keeps the two previous image lines in
//  line-delay RAMs. Emits only fully-interior windows: the output frame is (W-2)x(H-2).
// PARAMETERS
//  IMG_WIDTH_DATA  24   bits per pixel
//  IMG_WIDTH_LINE  800  pixels per line (W), >=3
//  IMG_HEIGHT      600  lines per frame (H), >=3
// PORTS
//  clk        in   1      single clock; all logic rising-edge
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      din carries a pixel this cycle
//  in_sof     in   1      qualified by in_valid: the pixel is (row 0, col 0) of a frame
//  din        in   DW     pixel data, DW = IMG_WIDTH_DATA
//  out_valid  out  1      win is valid this cycle
//  out_sof    out  1      with out_valid: first window of the frame
//  out_eof    out  1      with out_valid: last window of the frame
//  win        out  9*DW   {w00,w01,w02,w10,w11,w12,w20,w21,w22}, w00 in the MSBs
//  frame_err  out  1      one-cycle pulse on a framing violation
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in S_IDLE; col and row counters 0. RAM contents are not reset.
//  - FSM S_IDLE: in_valid&in_sof -> accept as (0,0), go to S_RUN.
//    In S_IDLE, in_valid&!in_sof -> pixel dropped, frame_err pulse.
//  - S_RUN: each in_valid advances col. col wraps W-1 -> 0 and row increments.
//    The pixel at (H-1,W-1) returns the FSM to S_IDLE.
//    A back-to-back in_sof on the next cycle is accepted.
//  - In S_RUN, in_valid&in_sof -> resync: pixel taken as (0,0) of a new frame, frame_err pulse.
//    Windows from the aborted frame already in the pipeline still drain.
//  - Window for pixel (r,c): w22=(r,c), w21=(r,c-1), w20=(r,c-2), w12=(r-1,c), ..., w00=(r-2,c-2).
//    Emitted only when r>=2 and c>=2.
//  - Latency: out_valid asserts exactly 2 clk after the in_valid cycle of pixel (r,c).
//    This holds with arbitrary in_valid gaps; no backpressure.
//    Stage 1, enabled by in_valid: read line RAMs at addr col, register din, set v1.
//    Stage 2, enabled by v1: shift the 3 window columns, register out_valid/sof/eof.
//  - Line RAMs: RAM0 holds row r-1, RAM1 holds row r-2.
//    At addr col: RAM1 <= RAM0[col], RAM0 <= din. Read-before-write returns old data.
//  - out_sof when (r,c)=(2,2); out_eof when (r,c)=(H-1,W-1). Both low whenever out_valid is low.
//  - Stale RAM data after a resync or reset never reaches win, because windows require r>=2.
//  - Counters are CNT_W=$clog2(max(W,H)) bits unsigned; no arithmetic wider than CNT_W+1.
//  - Reset mid-frame: next cycle all outputs 0 and FSM in S_IDLE. In-flight windows are discarded.
// STRUCTURE
//  - Shared package win_pkg: FSM state encoding (S_IDLE, S_RUN), window tap index localparams
//    (W00..W22), CNT_W computation function.
//  - Sub-module line_delay_ram (DW, DEPTH=W): single-port-address RAM with
//    registered read-before-write and read/write enable. Instantiated twice.
//  - Top level: FSM, counters, 2-stage pipeline and window shift registers.
// TESTING  (W=5, H=4, DW=8, pixel value = {row[3:0], col[3:0]})
//  1. Continuous frame, in_sof on the first pixel -> 6 windows.
//     First: win=={00,01,02,10,11,12,20,21,22} with out_sof. Last: w22=0x34 with out_eof.
//     Each window appears 2 clk after its pixel.
//  2. Same frame with random 0-3 cycle in_valid gaps -> identical 6 windows.
//     Each window still exactly 2 clk after its pixel.
//  3. Three pixels with in_valid=1, in_sof=0 after reset -> no out_valid, three frame_err pulses.
//  4. in_sof at pixel (2,3) mid-frame -> one frame_err pulse.
//     Windows of the new frame start only at its (2,2); w00 is new-frame data, not stale.
//  5. reset_n=0 for 1 cycle while out_valid is pending -> all outputs 0 next cycle.
//     Pending windows dropped. Next full frame is correct as in test 1.
//  6. Two frames back-to-back with no idle cycle -> 12 windows.
//     Two out_sof and two out_eof pulses; no frame_err.

Source files
------------

// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator: FSM encoding, window tap
// positions inside the packed output word, and counter sizing.
package win_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Tap slot index inside win; slot k occupies win[k*DW +: DW], so W00 sits in the MSBs.
    localparam int W00 = 8;
    localparam int W01 = 7;
    localparam int W02 = 6;
    localparam int W10 = 5;
    localparam int W11 = 4;
    localparam int W12 = 3;
    localparam int W20 = 2;
    localparam int W21 = 1;
    localparam int W22 = 0;

    function automatic int cnt_w(input int w, input int h);
        return (w > h) ? $clog2(w) : $clog2(h);
    endfunction

endpackage

// File: rtl/line_delay_ram.sv
// One line of pixel storage. Registered read-before-write on a single address;
// old_data exposes the word being overwritten so lines can be cascaded.
module line_delay_ram #(
    parameter int DW    = 24,
    parameter int DEPTH = 800,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] old_data
);

    logic [DW-1:0] mem [DEPTH];

    assign old_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// Raster pixel stream in, fully-interior 3x3 neighbourhoods out, two cycles
// after the pixel that completes each window.
module window3x3_gen
    import win_pkg::*;
#(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 800,
    parameter int IMG_HEIGHT     = 600
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [IMG_WIDTH_DATA-1:0]   din,
    output logic                        out_valid,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic [9*IMG_WIDTH_DATA-1:0] win,
    output logic                        frame_err
);

    // Both streams are valid-only: a beat transfers on every cycle its valid is
    // high; there is no ready, so the source never stalls and the sink must keep up.

    localparam int DW = IMG_WIDTH_DATA;
    localparam int CW = cnt_w(IMG_WIDTH_LINE, IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH_LINE - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    state_t        state, state_next;
    logic [CW-1:0] col, row;
    logic [CW-1:0] pos_col, pos_row, col_next, row_next;
    logic          take_sof, accept, err, last_px;

    logic          v1, e1, sof1, eof1;
    logic [DW-1:0] p1, q0, q1, ram0_old;
    logic [DW-1:0] tap [9];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) state_next = last_px ? S_IDLE : S_RUN;
    end

    // An in_sof pixel always restarts the frame at (0,0), whatever the state.
    always_comb begin
        take_sof = in_valid & in_sof;
        accept   = take_sof | (in_valid & (state == S_RUN));
        err      = in_valid & ((state == S_RUN) ? in_sof : ~in_sof);
        pos_col  = take_sof ? '0 : col;
        pos_row  = take_sof ? '0 : row;
        last_px  = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        col_next = pos_col + CW'(1);
        row_next = pos_row;
        if (pos_col == COL_LAST) begin
            col_next = '0;
            row_next = last_px ? '0 : pos_row + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            if (accept) begin
                col <= col_next;
                row <= row_next;
            end
        end
    end

    line_delay_ram #(.DW(DW), .DEPTH(IMG_WIDTH_LINE), .AW(CW)) u_ram0 (
        .clk      (clk),
        .en       (accept),
        .addr     (pos_col),
        .wdata    (din),
        .rdata    (q0),
        .old_data (ram0_old)
    );

    // RAM1 takes over the line RAM0 is evicting, so it always lags one row further.
    line_delay_ram #(.DW(DW), .DEPTH(IMG_WIDTH_LINE), .AW(CW)) u_ram1 (
        .clk      (clk),
        .en       (accept),
        .addr     (pos_col),
        .wdata    (ram0_old),
        .rdata    (q1),
        .old_data ()
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            e1   <= 1'b0;
            sof1 <= 1'b0;
            eof1 <= 1'b0;
            p1   <= '0;
        end else begin
            v1   <= accept;
            e1   <= accept && (pos_row >= TWO) && (pos_col >= TWO);
            sof1 <= accept && (pos_row == TWO) && (pos_col == TWO);
            eof1 <= accept && last_px;
            if (accept) p1 <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            for (int i = 0; i < 9; i++) tap[i] <= '0;
        end else begin
            out_valid <= v1 & e1;
            out_sof   <= v1 & sof1;
            out_eof   <= v1 & eof1;
            if (v1) begin
                tap[W00] <= tap[W01];
                tap[W01] <= tap[W02];
                tap[W02] <= q1;
                tap[W10] <= tap[W11];
                tap[W11] <= tap[W12];
                tap[W12] <= q0;
                tap[W20] <= tap[W21];
                tap[W21] <= tap[W22];
                tap[W22] <= p1;
            end
        end
    end

    for (genvar t = 0; t < 9; t++) begin : g_win
        assign win[t*DW +: DW] = tap[t];
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 5x4 frame of 8-bit pixels {row,col}.
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_sof;
  logic [DW-1:0]   din;
  logic            out_valid;
  logic            out_sof;
  logic            out_eof;
  logic [9*DW-1:0] win;
  logic            frame_err;

  window3x3_gen #(
    .IMG_WIDTH_DATA (DW),
    .IMG_WIDTH_LINE (W),
    .IMG_HEIGHT     (H)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .din       (din),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .win       (win),
    .frame_err (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // scoreboard: {sof, eof, win} plus the cycle at which it must appear
  logic [73:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          mon_en = 1'b0;
  int          win_seen = 0, sof_seen = 0, eof_seen = 0, err_seen = 0;
  logic [71:0] first_win = '0, last_win = '0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] x);
    return {4'(r), 4'(c)} ^ x;
  endfunction

  function automatic logic [73:0] exp_entry(input int r, input int c, input logic [7:0] x);
    logic [71:0] w;
    w = {pix(r-2, c-2, x), pix(r-2, c-1, x), pix(r-2, c, x),
         pix(r-1, c-2, x), pix(r-1, c-1, x), pix(r-1, c, x),
         pix(r,   c-2, x), pix(r,   c-1, x), pix(r,   c, x)};
    return {(r == 2 && c == 2), (r == H-1 && c == W-1), w};
  endfunction

  // driver tasks
  task automatic drive_px(input int r, input int c, input bit sof, input bit expect_win,
                          input logic [7:0] x);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    din      = pix(r, c, x);
    if (expect_win && r >= 2 && c >= 2) begin
      exp_q.push_back(exp_entry(r, c, x));
      exp_cyc_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      din      = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_frame(input int gap_max, input logic [7:0] x);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drive_px(r, c, (r == 0 && c == 0), 1'b1, x);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
  endtask

  // monitor: every emitted window must match the head of the queue at its due cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_err) err_seen++;
      if (out_valid) begin
        win_seen++;
        if (out_sof) begin sof_seen++; first_win = win; end
        if (out_eof) begin eof_seen++; last_win = win; end
        check("window_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("window", {out_sof, out_eof, win}, exp_q.pop_front());
          check("latency", cyc, exp_cyc_q.pop_front());
        end
      end else begin
        check("flags_idle", {out_sof, out_eof}, 2'b00);
      end
    end
  end

  int w0, s0, e0, f0;
  task automatic snap();
    w0 = win_seen; s0 = sof_seen; e0 = eof_seen; f0 = err_seen;
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    din      = '0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sof",   out_sof,   1'b0);
    check("rst_out_eof",   out_eof,   1'b0);
    check("rst_win",       win,       72'h0);
    check("rst_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // 1: continuous frame
    snap();
    send_frame(0, 8'h00);
    idle(4);
    check("t1_drained", exp_q.size(), 0);
    check("t1_windows", win_seen - w0, 6);
    check("t1_first",   first_win, 72'h00_01_02_10_11_12_20_21_22);
    check("t1_last_w22", last_win[7:0], 8'h34);
    check("t1_sof",     sof_seen - s0, 1);
    check("t1_eof",     eof_seen - e0, 1);
    check("t1_err",     err_seen - f0, 0);

    // 2: same frame with random input gaps
    snap();
    send_frame(3, 8'h00);
    idle(4);
    check("t2_drained", exp_q.size(), 0);
    check("t2_windows", win_seen - w0, 6);
    check("t2_err",     err_seen - f0, 0);

    // 3: pixels without sof while idle are dropped
    snap();
    repeat (3) drive_px(1, 1, 1'b0, 1'b0, 8'h00);
    idle(4);
    check("t3_err",     err_seen - f0, 3);
    check("t3_windows", win_seen - w0, 0);

    // 4: resync at what would have been pixel (2,3)
    snap();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) drive_px(r, c, (r == 0 && c == 0), 1'b1, 8'h00);
    for (int c = 0; c < 3; c++) drive_px(2, c, 1'b0, 1'b1, 8'h00);
    send_frame(0, 8'h88);
    idle(4);
    check("t4_drained", exp_q.size(), 0);
    check("t4_err",     err_seen - f0, 1);
    check("t4_windows", win_seen - w0, 7);
    check("t4_first",   first_win, 72'h88_89_8a_98_99_9a_a8_a9_aa);

    // 5: reset while windows are in flight
    snap();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) drive_px(r, c, (r == 0 && c == 0), 1'b1, 8'h00);
    drive_px(2, 0, 1'b0, 1'b1, 8'h00);
    drive_px(2, 1, 1'b0, 1'b1, 8'h00);
    drive_px(2, 2, 1'b0, 1'b1, 8'h00);
    drive_px(2, 3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_sof",   out_sof,   1'b0);
    check("t5_rst_eof",   out_eof,   1'b0);
    check("t5_rst_win",   win,       72'h0);
    check("t5_rst_err",   frame_err, 1'b0);
    idle(4);
    check("t5_windows_before", win_seen - w0, 1);
    snap();
    drive_px(0, 1, 1'b0, 1'b0, 8'h00);
    idle(3);
    check("t5_idle_after_rst", err_seen - f0, 1);
    snap();
    send_frame(0, 8'h00);
    idle(4);
    check("t5_drained", exp_q.size(), 0);
    check("t5_windows", win_seen - w0, 6);
    check("t5_first",   first_win, 72'h00_01_02_10_11_12_20_21_22);
    check("t5_err",     err_seen - f0, 0);

    // 6: two frames back to back
    snap();
    send_frame(0, 8'h00);
    send_frame(0, 8'h00);
    idle(4);
    check("t6_drained", exp_q.size(), 0);
    check("t6_windows", win_seen - w0, 12);
    check("t6_sof",     sof_seen - s0, 2);
    check("t6_eof",     eof_seen - e0, 2);
    check("t6_err",     err_seen - f0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
